phantom_rtc: RTL

//  On-CPLD replacement for the DS1215 phantom clock on the slot card's RAM/ROM chip-select path.

---
 rtl/rtc_pkg.sv | 13 +
 rtl/rtc_bcd_counter.sv | 19 +
 rtl/phantom_rtc.sv | 100 ++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and types for the phantom clock (recognition key, BCD field limits, FSM and direction encodings)
package rtc_pkg;
  localparam logic [63:0] KEY = 64'h5CA3_3AC5_5CA3_3AC5;
  localparam logic [7:0] FIELD_MIN = 8'h00;
  localparam logic [7:0] HUND_MAX = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MINUTE_MAX = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] DAY_MIN = 8'h01;
  localparam logic [7:0] DAY_MAX = 8'h07;
  typedef enum logic [1:0] {IDLE, MATCH, XFER} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_RD, DIR_WR} dir_t;
endpackage

// File: rtl/rtc_bcd_counter.sv
// rtc_bcd_counter: one BCD time field; clk, inc (count enable), load/din (parallel load, wins over inc), q (value), carry (wrap from MAX to MIN)
module rtc_bcd_counter #(
  parameter logic [7:0] MIN = 8'h00,
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic       clk,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] q,
  output logic       carry
);
  // Time survives reset, so the field has only a power-up value and no reset.
  logic [7:0] q_q = MIN;
  assign carry = inc && q_q == MAX;
  assign q = q_q;
  always_ff @(posedge clk)
    q_q <= load ? din : carry ? MIN : !inc ? q_q : q_q[3:0] >= 4'd9 ? {q_q[7:4] + 4'd1, 4'd0} : q_q + 8'd1;
endmodule

// File: rtl/phantom_rtc.sv
// phantom_rtc: phantom clock on the RAM/ROM select path.
// C7M/nRES clock and async active-low reset; CSin raw select; AccStb access commit strobe;
// nWE 6502 R/W; A0 serial data in; RAMROMCSgb gated select; RTCDOE D0 drive enable; RTCD0 serial time bit.
module phantom_rtc
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 71591
) (
  input  logic C7M,
  input  logic nRES,
  input  logic CSin,
  input  logic AccStb,
  input  logic nWE,
  input  logic A0,
  output logic RAMROMCSgb,
  output logic RTCDOE,
  output logic RTCD0
);
  localparam int PW = $clog2(TICK_DIV);
  state_t state_q, state_d;
  dir_t dir_q, dir_d;
  logic [5:0] key_ptr_q, key_ptr_d, bit_cnt_q, bit_cnt_d;
  logic [63:0] shift_q, shift_d, shift_in, tod;
  logic [PW-1:0] pre_q = '0;
  logic [7:0] date_q = 8'h01, month_q = 8'h01, year_q = 8'h00;
  logic [7:0] hund, sec, minute, hr, day;
  logic [3:0] cy;
  logic day_cy, unused_bits, acc, abort, load, tick;
  assign acc = AccStb && CSin;
  assign abort = (dir_q == DIR_RD && !nWE) || (dir_q == DIR_WR && nWE);
  assign shift_in = {A0, shift_q[63:1]};
  // Hours bit 7 is storage only and always reads back as zero.
  assign tod = {year_q, month_q, date_q, day, {1'b0, hr[6:0]}, minute, sec, hund};
  assign unused_bits = ^{hr[7], day_cy};
  assign tick = pre_q == PW'(TICK_DIV - 1);
  assign RAMROMCSgb = state_q != XFER && CSin;
  assign RTCDOE = state_q == XFER && CSin && nWE && dir_q != DIR_WR;
  assign RTCD0 = state_q == XFER && shift_q[0];
  always_ff @(posedge C7M or negedge nRES)
    if (!nRES) begin
      state_q <= IDLE;
      dir_q <= DIR_NONE;
      key_ptr_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      key_ptr_q <= key_ptr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
    end
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    key_ptr_d = key_ptr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    load = 1'b0;
    if (acc && state_q != XFER) begin
      if (!nWE && A0 == KEY[key_ptr_q]) begin
        key_ptr_d = key_ptr_q + 6'd1;
        state_d = key_ptr_q == 6'd63 ? XFER : MATCH;
        if (key_ptr_q == 6'd63) begin
          bit_cnt_d = '0;
          dir_d = DIR_NONE;
          shift_d = tod;
        end
      end else begin
        // A mismatching write may itself be the first key bit.
        key_ptr_d = {5'd0, !nWE && A0 == KEY[0]};
        state_d = !nWE && A0 == KEY[0] ? MATCH : IDLE;
      end
    end else if (acc && abort) begin
      state_d = IDLE;
      key_ptr_d = '0;
    end else if (acc) begin
      dir_d = nWE ? DIR_RD : DIR_WR;
      shift_d = nWE ? {1'b0, shift_q[63:1]} : shift_in;
      bit_cnt_d = bit_cnt_q + 6'd1;
      state_d = bit_cnt_q == 6'd63 ? IDLE : XFER;
      load = !nWE && bit_cnt_q == 6'd63;
    end
  end
  // Prescaler and calendar bytes survive reset; a load restarts the 1/100 s phase.
  always_ff @(posedge C7M) begin
    pre_q <= (load || tick) ? '0 : pre_q + 1'b1;
    if (load) {year_q, month_q, date_q} <= shift_in[63:40];
  end
  rtc_bcd_counter #(.MIN(FIELD_MIN), .MAX(HUND_MAX)) u_hund (
    .clk(C7M), .inc(tick), .load(load), .din(shift_in[7:0]), .q(hund), .carry(cy[0]));
  rtc_bcd_counter #(.MIN(FIELD_MIN), .MAX(SEC_MAX)) u_sec (
    .clk(C7M), .inc(cy[0]), .load(load), .din(shift_in[15:8]), .q(sec), .carry(cy[1]));
  rtc_bcd_counter #(.MIN(FIELD_MIN), .MAX(MINUTE_MAX)) u_min (
    .clk(C7M), .inc(cy[1]), .load(load), .din(shift_in[23:16]), .q(minute), .carry(cy[2]));
  rtc_bcd_counter #(.MIN(FIELD_MIN), .MAX(HOUR_MAX)) u_hr (
    .clk(C7M), .inc(cy[2]), .load(load), .din(shift_in[31:24]), .q(hr), .carry(cy[3]));
  rtc_bcd_counter #(.MIN(DAY_MIN), .MAX(DAY_MAX)) u_day (
    .clk(C7M), .inc(cy[3]), .load(load), .din(shift_in[39:32]), .q(day), .carry(day_cy));
endmodule
